// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-ramp path.
package pwm_pkg;
  localparam int DC_W    = 7;
  localparam int DC_MAX  = 100;
  localparam int FRAME_W = 8;
  localparam int DIV_W   = 4;

  typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} ramp_state_t;

  function automatic logic [DC_W-1:0] clamp_dc(input logic [DC_W-1:0] dc,
                                               input logic [DC_W-1:0] lim);
    return (dc > lim) ? lim : dc;
  endfunction
endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running frame counter kept in lock-step with the PWM generator count.
module pwm_frame_timer #(
  parameter int FRAME_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);
  logic [FRAME_W-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else        frame_cnt <= frame_cnt + 1'b1;
  end

  assign frame_tick = (frame_cnt == '1);
endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty ramp: moves dc_out one percent toward the target per permitted frame end.
module pwm_duty_ramp #(
  parameter int DC_W    = pwm_pkg::DC_W,
  parameter int DC_MAX  = pwm_pkg::DC_MAX,
  parameter int FRAME_W = pwm_pkg::FRAME_W,
  parameter int DIV_W   = pwm_pkg::DIV_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [DC_W-1:0] target_dc,
  input  logic [DIV_W-1:0] step_div,
  output logic [DC_W-1:0] dc_out,
  output logic            frame_tick,
  output logic            at_target,
  output logic            ramping_up,
  output logic            ramping_down
);
  import pwm_pkg::*;

  ramp_state_t      state;
  logic [DC_W-1:0]  tgt;
  logic [DIV_W-1:0] div_cnt;
  logic             frame_end;
  logic             step_ok;

  assign tgt = clamp_dc(target_dc, DC_W'(DC_MAX));

  pwm_frame_timer #(.FRAME_W(FRAME_W)) u_frame (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_end)
  );

  assign frame_tick = frame_end;
  // >= so that shrinking step_div below the running count releases a step at once
  assign step_ok    = frame_end && (div_cnt >= step_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_out  <= '0;
      div_cnt <= '0;
      state   <= IDLE;
    end else if (!enable) begin
      dc_out  <= '0;
      div_cnt <= '0;
      state   <= IDLE;
    end else begin
      if (dc_out < tgt)      state <= UP;
      else if (dc_out > tgt) state <= DOWN;
      else                   state <= HOLD;
      if (frame_end) div_cnt <= step_ok ? '0 : div_cnt + 1'b1;
      if (step_ok) begin
        if (dc_out < tgt)      dc_out <= dc_out + 1'b1;
        else if (dc_out > tgt) dc_out <= dc_out - 1'b1;
      end
    end
  end

  assign at_target    = (state == HOLD);
  assign ramping_up   = (state == UP);
  assign ramping_down = (state == DOWN);
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Randomized bench for pwm_duty_ramp against a frame-level reference model.
module tb_pwm_duty_ramp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] target_dc = '0;
  logic [3:0] step_div = '0;
  logic [6:0] dc_out;
  logic       frame_tick, at_target, ramping_up, ramping_down;

  int n_cmp = 0;
  int n_err = 0;
  // reference: edges since reset release, expected duty, frames since last step, status {at,up,down}
  int m_edges, m_dc, m_div, m_stat;

  pwm_duty_ramp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .target_dc    (target_dc),
    .step_div     (step_div),
    .dc_out       (dc_out),
    .frame_tick   (frame_tick),
    .at_target    (at_target),
    .ramping_up   (ramping_up),
    .ramping_down (ramping_down)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_dc = 0; m_div = 0; m_stat = 0;
  endtask

  // One clock edge of behaviour, using the inputs held across that edge.
  task automatic model_edge();
    int t;
    t = (int'(target_dc) > 100) ? 100 : int'(target_dc);
    if (!enable)        m_stat = 0;
    else if (m_dc < t)  m_stat = 3'b010;
    else if (m_dc > t)  m_stat = 3'b001;
    else                m_stat = 3'b100;
    if (!enable) begin
      m_dc = 0; m_div = 0;
    end else if (m_edges % 256 == 255) begin
      if (m_div >= int'(step_div)) begin
        m_div = 0;
        if (m_dc < t)      m_dc++;
        else if (m_dc > t) m_dc--;
      end else m_div++;
    end
    m_edges++;
  endtask

  task automatic check_now();
    chk("dc", int'(dc_out), m_dc);
    chk("tick", int'(frame_tick), (m_edges % 256 == 255) ? 1 : 0);
    chk("stat", int'({at_target, ramping_up, ramping_down}), m_stat);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_now();
    end
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dc", int'(dc_out), 0);
    chk("rst_stat", int'({at_target, ramping_up, ramping_down}), 0);
    chk("rst_tick", int'(frame_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // basic ramp to 5, step every frame
    enable = 1'b1; target_dc = 7'd5; step_div = 4'd0;
    run(255);  chk("p1_e255", int'(dc_out), 0);
    run(1);    chk("p1_e256", int'(dc_out), 1);
    run(1024); chk("p1_e1280", int'(dc_out), 5);
    chk("p1_up1280", int'(ramping_up), 1);
    run(1);    chk("p1_hold", int'(at_target), 1);
    run(200);

    // slow ramp: one step per 4 frames
    do_reset();
    target_dc = 7'd3; step_div = 4'd3;
    run(1023); chk("p2_e1023", int'(dc_out), 0);
    run(1);    chk("p2_e1024", int'(dc_out), 1);
    run(2048); chk("p2_e3072", int'(dc_out), 3);
    run(300);

    // clamp: 127 requested, saturates at 100
    do_reset();
    target_dc = 7'd127; step_div = 4'd0;
    run(110 * 256);
    chk("sat_dc", int'(dc_out), 100);
    chk("sat_hold", int'(at_target), 1);

    // reversal without overshoot
    do_reset();
    target_dc = 7'd4;
    run(1024); chk("rev_top", int'(dc_out), 4);
    target_dc = 7'd2;
    run(2);    chk("rev_down", int'(ramping_down), 1);
    run(254);  chk("rev_3", int'(dc_out), 3);
    run(256);  chk("rev_2", int'(dc_out), 2);
    run(50);

    // disable at 10, then restart
    do_reset();
    target_dc = 7'd20;
    run(2560); chk("dis_pre", int'(dc_out), 10);
    enable = 1'b0;
    run(1);    chk("dis_dc", int'(dc_out), 0);
    run(1);    chk("dis_stat", int'({at_target, ramping_up, ramping_down}), 0);
    run(40);
    enable = 1'b1;
    run(900);

    // reset pulse mid-ramp, first step again at 256
    do_reset();
    run(255);  chk("rr_e255", int'(dc_out), 0);
    run(1);    chk("rr_e256", int'(dc_out), 1);

    // randomized traffic
    for (int i = 0; i < 20000; i++) begin
      run(1);
      if ($urandom_range(0, 299) == 0) target_dc = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1999) == 0) step_div = 4'($urandom_range(0, 3));
      if (enable && $urandom_range(0, 2999) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      // exercise a target change landing exactly on a frame end
      if (m_edges % 256 == 254 && $urandom_range(0, 7) == 0)
        target_dc = 7'($urandom_range(0, 127));
      if (i == 12000) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Soft-start / slew-limiting stage directly upstream of the PWM generator. It takes a requested duty cycle in percent and drives the PWM's `dc` input toward it one percent at a time. Steps are taken only at PWM frame boundaries, so the generator never sees a mid-frame threshold jump. It keeps its own frame counter, which runs in lock-step with the generator's 8-bit count because both leave reset together and advance every cycle.

## Interface
Parameters:
- `DC_W` = 7: duty-cycle width.
- `DC_MAX` = 100: maximum legal duty (percent); larger requests clamp to this.
- `FRAME_W` = 8: frame counter width; frame length is 2^FRAME_W = 256 cycles.
- `DIV_W` = 4: width of the step divider.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `enable`  in  1: ramp enable; low forces the output to 0.
- `target_dc`  in  DC_W: requested duty in percent, sampled live.
- `step_div`  in  DIV_W: one step is taken per (step_div+1) frames.
- `dc_out`  out  DC_W: registered duty fed to the PWM `dc` input.
- `frame_tick`  out  1: high in the last cycle of each frame (frame_cnt==255).
- `at_target`  out  1: state==HOLD.
- `ramping_up`  out  1: state==UP.
- `ramping_down`  out  1: state==DOWN.

## Operation
- `tgt = min(target_dc, DC_MAX)`, combinational. Values 101..127 clamp to 100.
- `frame_cnt`: free-running, FRAME_W bits, wraps 255→0. It ignores `enable` and never stops, so it stays aligned to the PWM.
- `frame_end = (frame_cnt == 255)`. `frame_tick = frame_end` (decoded from the register).
- `div_cnt`: DIV_W bits, advanced only on `frame_end` while enabled:
  - if `div_cnt >= step_div`, then `div_cnt <= 0` and a step is permitted;
  - otherwise `div_cnt <= div_cnt + 1`.
  - The `>=` test means lowering `step_div` mid-count never stalls the ramp.
- Step on a permitted `frame_end`:
  - `dc_out < tgt`: `dc_out + 1`.
  - `dc_out > tgt`: `dc_out - 1`.
  - equal: hold.
  - Never overshoots; a target change mid-ramp reverses direction at the next step.
- State register (IDLE, UP, DOWN, HOLD), updated every cycle from the current `dc_out` and `tgt`:
  - `!enable` → IDLE;
  - else `dc_out < tgt` → UP; `dc_out > tgt` → DOWN; else HOLD.
- `enable` low (synchronous): next edge sets `dc_out <= 0`, `div_cnt <= 0`, state IDLE.
- `enable` re-asserted: the ramp restarts from 0 with `div_cnt` = 0.

## Timing
- Reset values: `frame_cnt`=0, `div_cnt`=0, `dc_out`=0, state IDLE. All status outputs are 0 during and after reset.
- `rst_n` asserted mid-ramp clears everything immediately (asynchronous). Release is synchronous to `clk`.
- `dc_out` changes only on the edge that wraps `frame_cnt` 255→0, or on the disable edge.
  - The PWM therefore applies the new duty starting at its count 0.
- Status outputs lag the `dc_out`/`tgt` change by one cycle, because they are registered.
- Sequence with `step_div`=0 and edges counted from reset release:
  - the first step lands on edge 256;
  - the k-th step lands on edge 256·k.
- Simultaneous `!enable` and `frame_end`: disable wins, and `dc_out` goes to 0.
- `target_dc` changing on a `frame_end` cycle: the new value is used for that step.

## Structure
- Package `pwm_pkg` holds:
  - `DC_MAX`, `DC_W`, `FRAME_W`;
  - the state enum `ramp_state_t` {IDLE, UP, DOWN, HOLD};
  - the clamp function `clamp_dc`.
- Sub-module `pwm_frame_timer`: the free-running FRAME_W counter plus the `frame_tick` decode. It is to be shared later with other frame-synchronous stages.
- The top of `pwm_duty_ramp` holds the divider, the `dc_out` register and the state register.

## Test plan
- Reset, enable=1, target=5, step_div=0 → `dc_out` is 0 through edge 255, then 1@256, 2@512, … 5@1280. `at_target`=1 from edge 1281. `ramping_up`=1 from edge 1 to edge 1280.
- target=3, step_div=3 → steps at edges 1024, 2048 and 3072 only. `frame_tick` pulses every 256 cycles throughout.
- target=127 held for 110 frames, step_div=0 → `dc_out` saturates at 100 with `at_target`=1. It never exceeds 100.
- Ramp up to `dc_out`=4, then set target=2 → next steps give 3, then 2. `ramping_down` is asserted between them. No overshoot past 4.
- `enable` dropped while `dc_out`=10 → `dc_out`=0 on the next edge, state IDLE. `frame_cnt` continues unbroken. Re-enable restarts the ramp from 0.
- `rst_n` pulsed low mid-cycle during a ramp → all outputs read 0 before the next clock edge. After release, the first step again lands on edge 256.
